// File: rtl/seq_pkg.sv
// Shared types and constants for the step sequencer.
package seq_pkg;

    localparam int unsigned NUM_STEPS      = 8;
    localparam int unsigned STEP_AW        = 3;
    localparam int unsigned FREQ_W         = 24;
    localparam int unsigned TEMPO_W        = 16;
    localparam int unsigned LEN_W          = 4;
    localparam int unsigned TICKS_PER_STEP = 16;

    localparam logic [LEN_W-1:0] LEN_REST = '0;

    // One pattern step as stored in the step memory.
    typedef struct packed {
        logic [FREQ_W-1:0] freq;
        logic [LEN_W-1:0]  len;
        logic              tie;
    } step_t;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

endpackage

// File: rtl/seq_tempo_gen.sv
// Tempo divider: counts 0..tempo_div and flags the tick cycle.
module seq_tempo_gen
    import seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_ena,
    input  logic               i_clr,
    input  logic [TEMPO_W-1:0] i_tempo_div,
    output logic               o_tick_c
);

    logic [TEMPO_W-1:0] r_tick_cnt;

    // >= so that lowering the divider mid-count ticks at once.
    assign o_tick_c = (r_tick_cnt >= i_tempo_div);

    // Tick counter: clear wins, otherwise advance and wrap on tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (i_clr) begin
            r_tick_cnt <= '0;
        end else if (i_ena) begin
            if (o_tick_c) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + TEMPO_W'(1);
            end
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Pattern step sequencer feeding frequency word and gate to the voice.
// Optional macro SEQ_TIE_EN: tied steps hold the gate across the boundary.
module step_sequencer
    import seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               run,
    input  logic [TEMPO_W-1:0] tempo_div,
    input  logic [STEP_AW-1:0] last_step,
    input  logic               wr_en,
    input  logic [STEP_AW-1:0] wr_addr,
    input  logic [FREQ_W-1:0]  wr_freq,
    input  logic [LEN_W-1:0]   wr_len,
    input  logic               wr_tie,
    output logic [FREQ_W-1:0]  freq_out,
    output logic               gate_out,
    output logic [STEP_AW-1:0] step_idx,
    output logic               step_pulse,
    output logic               busy
);

    localparam logic [LEN_W-1:0] SUB_LAST = LEN_W'(TICKS_PER_STEP - 1);

    state_t             r_state, w_state_nxt;
    step_t              r_mem [NUM_STEPS];
    logic [FREQ_W-1:0]  r_freq, w_freq_nxt;
    logic               r_gate, w_gate_nxt;
    logic [STEP_AW-1:0] r_idx, w_idx_nxt;
    logic               r_pulse, w_pulse_nxt;
    logic               r_busy, w_busy_nxt;
    logic [LEN_W-1:0]   r_sub, w_sub_nxt;
    logic [LEN_W-1:0]   r_cur_len, w_len_nxt;
    logic               w_clr, w_tick_ena, w_tick, w_hold;
    logic [STEP_AW-1:0] w_next_idx;

`ifdef SEQ_TIE_EN
    logic               r_cur_tie, w_tie_nxt;
    assign w_hold = r_cur_tie;
`else
    assign w_hold = 1'b0;
`endif

    assign freq_out   = r_freq;
    assign gate_out   = r_gate;
    assign step_idx   = r_idx;
    assign step_pulse = r_pulse;
    assign busy       = r_busy;

    // Wrap after last_step, or immediately if last_step was lowered below us.
    assign w_next_idx = (r_idx >= last_step) ? '0 : STEP_AW'(r_idx + 1'b1);

    seq_tempo_gen u_tempo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_ena       (w_tick_ena),
        .i_clr       (w_clr),
        .i_tempo_div (tempo_div),
        .o_tick_c    (w_tick)
    );

    // Step memory write port; a same-edge load still sees the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '{default: '0};
        end else if (wr_en) begin
            r_mem[wr_addr] <= step_t'{freq: wr_freq, len: wr_len, tie: wr_tie};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_freq_nxt  = r_freq;
        w_gate_nxt  = r_gate;
        w_idx_nxt   = r_idx;
        w_pulse_nxt = 1'b0;
        w_sub_nxt   = r_sub;
        w_len_nxt   = r_cur_len;
`ifdef SEQ_TIE_EN
        w_tie_nxt   = r_cur_tie;
`endif
        w_clr       = 1'b0;
        w_tick_ena  = 1'b0;
        case (r_state)
            IDLE: begin
                w_clr      = 1'b1;
                w_gate_nxt = 1'b0;
                w_idx_nxt  = '0;
                w_sub_nxt  = '0;
                if (run && ena) begin
                    w_state_nxt = PLAY;
                    w_freq_nxt  = r_mem[0].freq;
                    w_gate_nxt  = (r_mem[0].len != LEN_REST);
                    w_len_nxt   = r_mem[0].len;
`ifdef SEQ_TIE_EN
                    w_tie_nxt   = r_mem[0].tie;
`endif
                    w_pulse_nxt = 1'b1;
                end
            end
            PLAY: begin
                if (!run) begin
                    w_state_nxt = IDLE;
                    w_clr       = 1'b1;
                    w_gate_nxt  = 1'b0;
                    w_idx_nxt   = '0;
                    w_sub_nxt   = '0;
                end else if (ena) begin
                    w_tick_ena = 1'b1;
                    if (w_tick) begin
                        w_sub_nxt = r_sub + LEN_W'(1);
                        if (r_sub == SUB_LAST) begin
                            w_idx_nxt   = w_next_idx;
                            w_freq_nxt  = r_mem[w_next_idx].freq;
                            w_gate_nxt  = (r_mem[w_next_idx].len != LEN_REST);
                            w_len_nxt   = r_mem[w_next_idx].len;
`ifdef SEQ_TIE_EN
                            w_tie_nxt   = r_mem[w_next_idx].tie;
`endif
                            w_pulse_nxt = 1'b1;
                        end else if ((r_sub + LEN_W'(1)) == r_cur_len && !w_hold) begin
                            w_gate_nxt = 1'b0;
                        end
                    end
                end
            end
        endcase
        w_busy_nxt = (w_state_nxt == PLAY);
    end

    // Output and step-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_freq    <= '0;
            r_gate    <= 1'b0;
            r_idx     <= '0;
            r_pulse   <= 1'b0;
            r_busy    <= 1'b0;
            r_sub     <= '0;
            r_cur_len <= '0;
`ifdef SEQ_TIE_EN
            r_cur_tie <= 1'b0;
`endif
        end else begin
            r_freq    <= w_freq_nxt;
            r_gate    <= w_gate_nxt;
            r_idx     <= w_idx_nxt;
            r_pulse   <= w_pulse_nxt;
            r_busy    <= w_busy_nxt;
            r_sub     <= w_sub_nxt;
            r_cur_len <= w_len_nxt;
`ifdef SEQ_TIE_EN
            r_cur_tie <= w_tie_nxt;
`endif
        end
    end

endmodule
